// File: rtl/pc_ret_stack_unit_pkg.sv
// Shared definitions for the program-counter stage: next-PC select codes and
// default widths.
package pc_ret_stack_unit_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int OFFS_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  localparam logic [1:0] SEL_NEXT   = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_RSVD   = 2'b11;
endpackage

// File: rtl/pc_ret_stack_unit_ret_stack.sv
// Return-address LIFO: storage, entry count and full/empty status.
// The caller never asserts push and pop together and never pops when empty.
module ret_stack #(
  parameter int W     = 12,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          init_signal,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] topIdx;

  assign topIdx = count - 1'b1;
  assign top    = mem[topIdx[IW-1:0]];
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);

  always_ff @(posedge clock or negedge init_signal) begin
    if (!init_signal) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + 1'b1;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[count[IW-1:0]] <= din;
    end
  end
endmodule

// File: rtl/pc_ret_stack_unit.sv
// PC register, next-address selection and sticky stack error flags; the
// return addresses live in the ret_stack LIFO.
module pc_ret_stack_unit
  import pc_ret_stack_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OFFS_W = OFFS_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              init_signal,
  input  logic              enablePC,
  input  logic [1:0]        selectAdress,
  input  logic              push,
  input  logic              pop,
  input  logic              RET,
  input  logic [ADDR_W-1:0] Adress,
  input  logic [OFFS_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] pc,
  output logic [CW-1:0]     stack_count,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_overflow,
  output logic              stack_underflow
);
  logic [ADDR_W-1:0] pcPlus1, pcBranch, pcNext, stkTop;
  logic              stkPush, stkPop, setOvf, setUnf;

  assign pcPlus1  = pc + 1'b1;
  assign pcBranch = pcPlus1 + {{(ADDR_W - OFFS_W){branch_offset[OFFS_W-1]}}, branch_offset};

  // Return/pop outranks call; a dropped or empty-stack operation still advances the PC.
  always_comb begin
    pcNext  = pc;
    stkPush = 1'b0;
    stkPop  = 1'b0;
    setOvf  = 1'b0;
    setUnf  = 1'b0;
    if (enablePC) begin
      if (RET || pop) begin
        if (stack_empty) begin
          pcNext = pcPlus1;
          setUnf = 1'b1;
        end else begin
          stkPop = 1'b1;
          pcNext = RET ? stkTop : pcPlus1;
        end
      end else if (push) begin
        pcNext = Adress;
        if (stack_full) setOvf = 1'b1;
        else            stkPush = 1'b1;
      end else begin
        case (selectAdress)
          SEL_BRANCH: pcNext = pcBranch;
          SEL_JUMP:   pcNext = Adress;
          default:    pcNext = pcPlus1;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge init_signal) begin
    if (!init_signal) begin
      pc              <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      pc <= pcNext;
      if (setOvf) stack_overflow  <= 1'b1;
      if (setUnf) stack_underflow <= 1'b1;
    end
  end

  ret_stack #(
    .W     (ADDR_W),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clock       (clock),
    .init_signal (init_signal),
    .push        (stkPush),
    .pop         (stkPop),
    .din         (pcPlus1),
    .top         (stkTop),
    .count       (stack_count),
    .full        (stack_full),
    .empty       (stack_empty)
  );
endmodule

// File: tb/tb_pc_ret_stack_unit.sv
// Directed bench for pc_ret_stack_unit: sequencing, branches, nested calls,
// stack full/empty limits, wrap-around, enable gating and async reset.
module tb_pc_ret_stack_unit;
  localparam int ADDR_W = 12;
  localparam int OFFS_W = 8;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              init_signal = 1'b0;
  logic              enablePC = 1'b0;
  logic [1:0]        selectAdress = 2'b00;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              RET = 1'b0;
  logic [ADDR_W-1:0] Adress = '0;
  logic [OFFS_W-1:0] branch_offset = '0;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     stack_count;
  logic              stack_full, stack_empty, stack_overflow, stack_underflow;

  int testsRun = 0;
  int testsFailed = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] expPc;

  pc_ret_stack_unit #(.ADDR_W(ADDR_W), .OFFS_W(OFFS_W), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .init_signal     (init_signal),
    .enablePC        (enablePC),
    .selectAdress    (selectAdress),
    .push            (push),
    .pop             (pop),
    .RET             (RET),
    .Adress          (Adress),
    .branch_offset   (branch_offset),
    .pc              (pc),
    .stack_count     (stack_count),
    .stack_full      (stack_full),
    .stack_empty     (stack_empty),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [ADDR_W-1:0] ePc, input int eCnt);
    chk({tag, ".pc"}, 32'(pc), 32'(ePc));
    chk({tag, ".count"}, 32'(stack_count), 32'(eCnt));
    chk({tag, ".full"}, 32'(stack_full), 32'(eCnt == DEPTH));
    chk({tag, ".empty"}, 32'(stack_empty), 32'(eCnt == 0));
  endtask

  task automatic checkFlags(input string tag, input logic eOvf, input logic eUnf);
    chk({tag, ".ovf"}, 32'(stack_overflow), 32'(eOvf));
    chk({tag, ".unf"}, 32'(stack_underflow), 32'(eUnf));
  endtask

  // driver: apply one control word for one rising edge, sample 1 time unit later
  task automatic step(input logic en, input logic [1:0] sel, input logic pu, input logic po,
                      input logic rt, input logic [ADDR_W-1:0] adr, input logic [OFFS_W-1:0] off);
    enablePC = en; selectAdress = sel; push = pu; pop = po; RET = rt;
    Adress = adr; branch_offset = off;
    @(posedge clock);
    #1;
    enablePC = 1'b0; push = 1'b0; pop = 1'b0; RET = 1'b0; selectAdress = 2'b00;
  endtask

  task automatic nextPc();                          step(1, 2'b00, 0, 0, 0, '0, '0); endtask
  task automatic jump(input logic [ADDR_W-1:0] a);  step(1, 2'b10, 0, 0, 0, a, '0);  endtask
  task automatic branch(input logic [OFFS_W-1:0] o); step(1, 2'b01, 0, 0, 0, '0, o); endtask
  task automatic call(input logic [ADDR_W-1:0] a);  step(1, 2'b10, 1, 0, 0, a, '0);  endtask
  task automatic ret();                             step(1, 2'b00, 0, 1, 1, '0, '0); endtask

  initial begin
    // reset
    #12;
    checkState("reset", 12'h000, 0);
    checkFlags("reset", 0, 0);
    init_signal = 1'b1;
    @(posedge clock);
    #1;

    // sequential fetch
    for (int i = 1; i <= 5; i++) begin
      nextPc();
      checkState($sformatf("seq%0d", i), 12'(i), 0);
    end

    // branches
    jump(12'h010);
    checkState("jump010", 12'h010, 0);
    branch(8'hFC);
    checkState("branch_m4", 12'h00D, 0);
    branch(8'h05);
    checkState("branch_p5", 12'h013, 0);

    // single call / return
    jump(12'h020);
    call(12'h100);
    checkState("call100", 12'h100, 1);
    nextPc();
    checkState("in_sub", 12'h101, 1);
    ret();
    checkState("ret021", 12'h021, 0);

    // nested calls
    jump(12'h005);
    call(12'h200);
    checkState("ncall200", 12'h200, 1);
    call(12'h300);
    checkState("ncall300", 12'h300, 2);
    ret();
    checkState("nret201", 12'h201, 1);
    ret();
    checkState("nret006", 12'h006, 0);

    // enable low ignores everything
    step(0, 2'b10, 1, 0, 0, 12'h3AB, '0);
    checkState("disabled", 12'h006, 0);
    checkFlags("disabled", 0, 0);

    // wrap-around
    jump(12'hFFF);
    nextPc();
    checkState("wrap_inc", 12'h000, 0);
    branch(8'hFC);
    checkState("wrap_back", 12'hFFD, 0);
    branch(8'h05);
    checkState("wrap_fwd", 12'h003, 0);

    // push together with return: return wins, no flags
    call(12'h400);
    checkState("call400", 12'h400, 1);
    step(1, 2'b10, 1, 1, 1, 12'h555, '0);
    checkState("push_ret", 12'h004, 0);
    checkFlags("push_ret", 0, 0);

    // pop without RET discards top and advances
    call(12'h080);
    step(1, 2'b00, 0, 1, 0, '0, '0);
    checkState("pop_only", 12'h081, 0);

    // fill the stack, then overflow
    expPc = 12'h081;
    for (int i = 0; i <= DEPTH; i++) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(expPc + 1'b1);
      expPc = 12'h700 + 12'(i * 16);
      call(expPc);
      checkState($sformatf("fill%0d", i), expPc, exp_q.size());
    end
    checkFlags("overflow", 1, 0);

    // drain, then underflow
    for (int i = 0; i < DEPTH; i++) begin
      expPc = exp_q.pop_back();
      ret();
      checkState($sformatf("drain%0d", i), expPc, exp_q.size());
    end
    chk("drain_last", 32'(pc), 32'h082);
    ret();
    checkState("underflow", 12'h083, 0);
    checkFlags("underflow", 1, 1);
    nextPc();
    checkFlags("sticky", 1, 1);

    // asynchronous reset in the middle of a call sequence
    call(12'h123);
    checkState("pre_reset", 12'h123, 1);
    #2;
    init_signal = 1'b0;
    #1;
    checkState("async_reset", 12'h000, 0);
    checkFlags("async_reset", 0, 0);
    #2;
    init_signal = 1'b1;
    nextPc();
    checkState("post_reset", 12'h001, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
